// File: rtl/detector_jogada_pkg.sv
// detector_jogada_pkg: state encoding shared by the button front-end and its debug display
package detector_jogada_pkg;
  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRANDO     = 3'd1,
    REGISTRA      = 3'd2,
    ESPERA_SOLTAR = 3'd3,
    SOLTANDO      = 3'd4
  } estado_t;
  localparam int DEBOUNCE_DEFAULT = 10;
endpackage

// File: rtl/detector_jogada_sincronizador.sv
// sincronizador_2ff: two-flop synchroniser for asynchronous button levels
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clock) begin
    if (reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: synchronises, debounces and captures one pattern per button press
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int WIDTH           = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             limpa,
  input  logic             habilita,
  input  logic [WIDTH-1:0] botoes,
  output logic [WIDTH-1:0] jogada,
  output logic             jogada_feita,
  output logic             jogada_invalida,
  output logic             tem_jogada,
  output logic [2:0]       db_estado
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  estado_t estado;
  logic [WIDTH-1:0] botoes_s, amostra;
  logic [CW-1:0] cnt;
  sincronizador_2ff #(.WIDTH(WIDTH)) u_sync (
    .clock(clock),
    .reset(reset),
    .d(botoes),
    .q(botoes_s)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= OCIOSO;
      amostra         <= '0;
      cnt             <= '0;
      jogada          <= '0;
      jogada_invalida <= 1'b0;
      tem_jogada      <= 1'b0;
    end else begin
      tem_jogada <= |botoes_s;
      if (limpa) begin
        jogada          <= '0;
        jogada_invalida <= 1'b0;
      end
      case (estado)
        OCIOSO:
          if (|botoes_s) begin
            estado  <= FILTRANDO;
            amostra <= botoes_s;
            cnt     <= '0;
          end
        FILTRANDO:
          if (botoes_s == '0) estado <= OCIOSO;
          else if (botoes_s != amostra) begin
            amostra <= botoes_s;
            cnt     <= '0;
          end else if (cnt == CNT_MAX) begin
            // a disabled or cleared acceptance still consumes the press
            if (habilita && !limpa) begin
              estado          <= REGISTRA;
              jogada          <= amostra;
              jogada_invalida <= $countones(amostra) != 1;
            end else estado <= ESPERA_SOLTAR;
          end else cnt <= cnt + 1'b1;
        REGISTRA: estado <= ESPERA_SOLTAR;
        ESPERA_SOLTAR:
          if (botoes_s == '0) begin
            estado <= SOLTANDO;
            cnt    <= '0;
          end
        SOLTANDO:
          if (|botoes_s) estado <= ESPERA_SOLTAR;
          else if (cnt == CNT_MAX) estado <= OCIOSO;
          else cnt <= cnt + 1'b1;
        default: estado <= OCIOSO;
      endcase
    end
  end
  assign jogada_feita = estado == REGISTRA;
  assign db_estado    = estado;
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed and random presses checked against a run-length reference model
module tb_detector_jogada;
  localparam int D = 10;
  localparam int W = 4;
  logic clock = 1'b0;
  logic reset, limpa, habilita, jogada_feita, jogada_invalida, tem_jogada;
  logic [W-1:0] botoes, jogada;
  logic [2:0] db_estado;
  int checks = 0, errors = 0;
  detector_jogada #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .limpa(limpa),
    .habilita(habilita),
    .botoes(botoes),
    .jogada(jogada),
    .jogada_feita(jogada_feita),
    .jogada_invalida(jogada_invalida),
    .tem_jogada(tem_jogada),
    .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  // reference model: delay line for the synchroniser, run lengths of equal pressed and released samples
  logic [W-1:0] m_d1, m_d2, m_last, m_jog;
  logic m_inv, m_tem, m_reg, m_busy;
  int m_run, m_zrun;
  int edge_no, pulses, last_pulse, first_tem, mm, bad_edge;
  logic [W-1:0] jog_pulse;
  logic inv_pulse;
  logic [9:0] bad_obs, bad_exp;
  task automatic model_step();
    logic [W-1:0] s;
    if (reset) begin
      {m_d1, m_d2, m_last, m_jog} = '0;
      {m_inv, m_tem, m_reg, m_busy} = '0;
      m_run = 0;
      m_zrun = 0;
      return;
    end
    s = m_d2;
    m_d2 = m_d1;
    m_d1 = botoes;
    m_tem = |s;
    if (limpa) begin
      m_jog = '0;
      m_inv = 1'b0;
    end
    if (m_reg) begin
      m_reg = 1'b0;
      m_busy = 1'b1;
      m_zrun = 0;
    end else if (m_busy) begin
      m_zrun = (s == '0) ? m_zrun + 1 : 0;
      if (m_zrun == D + 1) begin
        m_busy = 1'b0;
        m_run = 0;
      end
    end else begin
      m_run = (s == '0) ? 0 : (m_run > 0 && s == m_last) ? m_run + 1 : 1;
      m_last = s;
      if (m_run == D + 1) begin
        m_run = 0;
        if (habilita && !limpa) begin
          m_reg = 1'b1;
          m_jog = s;
          m_inv = $countones(s) != 1;
        end else begin
          m_busy = 1'b1;
          m_zrun = 0;
        end
      end
    end
  endtask
  function automatic logic [2:0] db_model();
    return m_reg ? 3'd2 : m_busy ? (m_zrun > 0 ? 3'd4 : 3'd3) : (m_run > 0 ? 3'd1 : 3'd0);
  endfunction
  task automatic seg();
    edge_no = 0;
    pulses = 0;
    last_pulse = -1;
    first_tem = -1;
    mm = 0;
  endtask
  task automatic tick(input logic [W-1:0] b, input logic h, input logic l, input logic r);
    logic [9:0] e, o;
    @(negedge clock);
    botoes = b;
    habilita = h;
    limpa = l;
    reset = r;
    model_step();
    @(posedge clock);
    #1;
    edge_no++;
    e = {m_jog, m_reg, m_inv, m_tem, db_model()};
    o = {jogada, jogada_feita, jogada_invalida, tem_jogada, db_estado};
    if (o !== e) begin
      if (mm == 0) begin
        bad_obs = o;
        bad_exp = e;
        bad_edge = edge_no;
      end
      mm++;
    end
    if (jogada_feita === 1'b1) begin
      pulses++;
      last_pulse = edge_no;
      jog_pulse = jogada;
      inv_pulse = jogada_invalida;
    end
    if (tem_jogada === 1'b1 && first_tem < 0) first_tem = edge_no;
  endtask
  task automatic test_reset();
    seg();
    repeat (2) tick('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({jogada, jogada_feita, jogada_invalida, tem_jogada, db_estado} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0", {jogada, jogada_feita, jogada_invalida, tem_jogada, db_estado});
    end
    repeat (50) tick('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL idle_pulses got %0d expected 0", pulses);
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL reset_model edge %0d got %b expected %b", bad_edge, bad_obs, bad_exp);
    end
  endtask
  task automatic test_single_press();
    seg();
    repeat (20) tick(4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (20) tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 1 || last_pulse !== 13) begin
      errors++;
      $display("FAIL single_pulse got %0d pulses at edge %0d expected 1 at 13", pulses, last_pulse);
    end
    checks++;
    if (jog_pulse !== 4'b0010 || inv_pulse !== 1'b0) begin
      errors++;
      $display("FAIL single_capture got %b inv %b expected 0010 inv 0", jog_pulse, inv_pulse);
    end
    checks++;
    if (first_tem !== 3) begin
      errors++;
      $display("FAIL tem_latency got edge %0d expected 3", first_tem);
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL single_model edge %0d got %b expected %b", bad_edge, bad_obs, bad_exp);
    end
  endtask
  task automatic test_bounce();
    seg();
    for (int i = 0; i < 12; i++) tick((i % 3 != 2) ? 4'b0001 : 4'b0000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL bounce_early got %0d pulses expected 0", pulses);
    end
    seg();
    repeat (25) tick(4'b0001, 1'b1, 1'b0, 1'b0);
    repeat (20) tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 1 || last_pulse !== 13) begin
      errors++;
      $display("FAIL bounce_pulse got %0d pulses at edge %0d expected 1 at 13", pulses, last_pulse);
    end
    repeat (5) tick(4'b0001, 1'b1, 1'b0, 1'b0);
    repeat (25) tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL short_press got %0d pulses expected 1 total", pulses);
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL bounce_model edge %0d got %b expected %b", bad_edge, bad_obs, bad_exp);
    end
  endtask
  task automatic test_invalid();
    seg();
    repeat (20) tick(4'b0101, 1'b1, 1'b0, 1'b0);
    repeat (20) tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 1 || jog_pulse !== 4'b0101 || inv_pulse !== 1'b1) begin
      errors++;
      $display("FAIL invalid_capture got %0d pulses %b inv %b expected 1 0101 inv 1", pulses, jog_pulse, inv_pulse);
    end
  endtask
  task automatic test_habilita_limpa();
    seg();
    repeat (20) tick(4'b0100, 1'b0, 1'b0, 1'b0);
    repeat (20) tick('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pulses !== 0 || jogada !== 4'b0101) begin
      errors++;
      $display("FAIL disabled_press got %0d pulses jogada %b expected 0 and 0101", pulses, jogada);
    end
    tick('0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (jogada !== 4'b0000 || jogada_invalida !== 1'b0) begin
      errors++;
      $display("FAIL limpa_clear got %b inv %b expected 0000 inv 0", jogada, jogada_invalida);
    end
    seg();
    repeat (12) tick(4'b0010, 1'b1, 1'b0, 1'b0);
    tick(4'b0010, 1'b1, 1'b1, 1'b0);
    repeat (10) tick(4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (20) tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 0 || jogada !== 4'b0000) begin
      errors++;
      $display("FAIL limpa_wins got %0d pulses jogada %b expected 0 and 0000", pulses, jogada);
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL limpa_model edge %0d got %b expected %b", bad_edge, bad_obs, bad_exp);
    end
  endtask
  task automatic test_hold_and_reset();
    seg();
    repeat (100) tick(4'b1000, 1'b1, 1'b0, 1'b0);
    repeat (20) tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 1 || jog_pulse !== 4'b1000) begin
      errors++;
      $display("FAIL long_hold got %0d pulses %b expected 1 of 1000", pulses, jog_pulse);
    end
    seg();
    repeat (7) tick(4'b0001, 1'b1, 1'b0, 1'b0);
    tick(4'b0001, 1'b1, 1'b0, 1'b1);
    repeat (30) tick(4'b0001, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pulses !== 1 || last_pulse !== 21) begin
      errors++;
      $display("FAIL reset_midpress got %0d pulses at edge %0d expected 1 at 21", pulses, last_pulse);
    end
    repeat (20) tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL hold_model edge %0d got %b expected %b", bad_edge, bad_obs, bad_exp);
    end
  endtask
  task automatic test_random();
    logic [W-1:0] pats[8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'hF};
    logic [W-1:0] b;
    logic h;
    int n;
    seg();
    for (int k = 0; k < 200; k++) begin
      b = pats[$urandom_range(0, 7)];
      h = $urandom_range(0, 3) != 0;
      n = $urandom_range(1, 25);
      for (int i = 0; i < n; i++)
        tick(b, h, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL random_model %0d bad edges, first at %0d got %b expected %b", mm, bad_edge, bad_obs, bad_exp);
    end
  endtask
  initial begin
    botoes = '0;
    habilita = 1'b0;
    limpa = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_invalid();
    test_habilita_limpa();
    test_hold_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
